riscv_lsu: RTL and testbench

Memory-stage load/store unit for the RV32I pipeline. It consumes the MEM-stage fields of the control bus (dmem_rd, dmem_wr, ld_st_funct3), the ALU-computed effective address and the rs2 store data. It drives a word-organised, byte-addressed data memory over a req/ready handshake and stalls the pipeline until the access completes. Load results are returned aligned and sign- or zero-extended for the WB stage.

---
 rtl/riscv_lsu_pkg.sv | 69 ++++++
 rtl/riscv_lsu_if.sv | 27 ++
 rtl/riscv_lsu_load_align.sv | 29 ++
 rtl/riscv_lsu.sv | 156 +++++++++++++++
 tb/tb_riscv_lsu.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the RV32I memory-stage load/store unit.
//   - operand/address widths and byte-enable count
//   - load/store funct3 encodings
//   - LSU FSM state type
//   - helpers for access legality, byte-enable and write-lane generation
package riscv_lsu_pkg;

    localparam int unsigned NB_WORD  = 32;
    localparam int unsigned MEM_SIZE = 128;
    localparam int unsigned NB_ADDR  = $clog2(MEM_SIZE);
    localparam int unsigned NB_BE    = NB_WORD / 8;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } lsu_state_t;

    function automatic logic load_ok(logic [2:0] f3, logic [1:0] off);
        case (f3)
            LB, LBU: load_ok = 1'b1;
            LH, LHU: load_ok = ~off[0];
            LW:      load_ok = (off == 2'b00);
            default: load_ok = 1'b0;
        endcase
    endfunction

    function automatic logic store_ok(logic [2:0] f3, logic [1:0] off);
        case (f3)
            SB:      store_ok = 1'b1;
            SH:      store_ok = ~off[0];
            SW:      store_ok = (off == 2'b00);
            default: store_ok = 1'b0;
        endcase
    endfunction

    // Size is encoded in funct3[1:0] for both loads and stores.
    function automatic logic [3:0] gen_be(logic [2:0] f3, logic [1:0] off);
        case (f3[1:0])
            2'b00:   gen_be = 4'b0001 << off;
            2'b01:   gen_be = 4'b0011 << {off[1], 1'b0};
            default: gen_be = 4'b1111;
        endcase
    endfunction

    // Replicate the store operand across all lanes; byte enables pick the live one.
    function automatic logic [31:0] gen_wdata(logic [2:0] f3, logic [31:0] data);
        case (f3[1:0])
            2'b00:   gen_wdata = {4{data[7:0]}};
            2'b01:   gen_wdata = {2{data[15:0]}};
            default: gen_wdata = data;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Data-memory bus between the LSU (master) and a word-organised, byte-addressed memory (slave).
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata : request, held stable until mem_ready
//   mem_ready : request accepted/completed this cycle
//   mem_rdata : read word, valid with mem_ready on a read
interface riscv_lsu_if #(
    parameter int unsigned NB_WORD = 32,
    parameter int unsigned NB_ADDR = 7,
    parameter int unsigned NB_BE   = 4
);
    logic               mem_req;
    logic               mem_we;
    logic [NB_ADDR-1:0] mem_addr;
    logic [NB_BE-1:0]   mem_be;
    logic [NB_WORD-1:0] mem_wdata;
    logic               mem_ready;
    logic [NB_WORD-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/riscv_lsu_load_align.sv
// Combinational load-lane alignment: shifts the read word down by the byte offset and
// sign/zero-extends according to the load funct3.
//   rdata_i  : raw memory word
//   offset_i : address bits [1:0]
//   funct3_i : LB/LH/LW/LBU/LHU
//   data_o   : extended load result
module riscv_lsu_load_align
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned NB_WORD = 32
) (
    input  logic [NB_WORD-1:0] rdata_i,
    input  logic [1:0]         offset_i,
    input  logic [2:0]         funct3_i,
    output logic [NB_WORD-1:0] data_o
);
    logic [NB_WORD-1:0] shifted;

    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        case (funct3_i)
            LB:      data_o = {{(NB_WORD-8){shifted[7]}}, shifted[7:0]};
            LH:      data_o = {{(NB_WORD-16){shifted[15]}}, shifted[15:0]};
            LBU:     data_o = {{(NB_WORD-8){1'b0}}, shifted[7:0]};
            LHU:     data_o = {{(NB_WORD-16){1'b0}}, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end
endmodule

// File: rtl/riscv_lsu.sv
// RV32I memory-stage load/store unit.
//   clk, rst         : clock, synchronous active-high reset
//   in_valid, dmem_rd, dmem_wr, ld_st_funct3, addr, store_data : MEM-stage request
//   stall            : hold IF..MEM (combinational)
//   load_data/valid  : extended load result, valid in DONE for loads
//   fault            : one-cycle pulse for a misaligned/illegal access
//   dmem             : data-memory bus (master side)
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned NB_WORD = riscv_lsu_pkg::NB_WORD,
    parameter int unsigned NB_ADDR = riscv_lsu_pkg::NB_ADDR,
    parameter int unsigned NB_BE   = riscv_lsu_pkg::NB_BE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               dmem_rd,
    input  logic               dmem_wr,
    input  logic [2:0]         ld_st_funct3,
    input  logic [NB_WORD-1:0] addr,
    input  logic [NB_WORD-1:0] store_data,
    output logic               stall,
    output logic [NB_WORD-1:0] load_data,
    output logic               load_valid,
    output logic               fault,
    riscv_lsu_if.master        dmem
);
    lsu_state_t state_q, state_d;

    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [NB_ADDR-1:0] mem_addr_q, mem_addr_d;
    logic [NB_BE-1:0]   mem_be_q, mem_be_d;
    logic [NB_WORD-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         offset_q, offset_d;
    logic [NB_WORD-1:0] load_data_q, load_data_d;
    logic               load_valid_q, load_valid_d;
    logic               fault_q, fault_d;

    logic               access;
    logic               legal;
    logic [NB_WORD-1:0] aligned;
    logic               unused_addr;

    // Upper address bits wrap away: memory is only MEM_SIZE bytes.
    assign unused_addr = ^addr[NB_WORD-1:NB_ADDR];

    assign access = in_valid & (dmem_rd | dmem_wr);
    assign legal  = ~(dmem_rd & dmem_wr) &
                    (dmem_rd ? load_ok(ld_st_funct3, addr[1:0])
                             : store_ok(ld_st_funct3, addr[1:0]));

    riscv_lsu_load_align #(
        .NB_WORD (NB_WORD)
    ) u_load_align (
        .rdata_i  (dmem.mem_rdata),
        .offset_i (offset_q),
        .funct3_i (funct3_q),
        .data_o   (aligned)
    );

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        funct3_d     = funct3_q;
        offset_d     = offset_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        fault_d      = 1'b0;
        stall        = 1'b0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (legal) begin
                        stall       = 1'b1;
                        state_d     = BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = dmem_wr;
                        mem_addr_d  = {addr[NB_ADDR-1:2], 2'b00};
                        mem_be_d    = gen_be(ld_st_funct3, addr[1:0]);
                        mem_wdata_d = gen_wdata(ld_st_funct3, store_data);
                        funct3_d    = ld_st_funct3;
                        offset_d    = addr[1:0];
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (dmem.mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (!mem_we_q) begin
                        load_data_d  = aligned;
                        load_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            funct3_q     <= '0;
            offset_q     <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            funct3_q     <= funct3_d;
            offset_q     <= offset_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            fault_q      <= fault_d;
        end
    end

    assign dmem.mem_req   = mem_req_q;
    assign dmem.mem_we    = mem_we_q;
    assign dmem.mem_addr  = mem_addr_q;
    assign dmem.mem_be    = mem_be_q;
    assign dmem.mem_wdata = mem_wdata_q;
    assign load_data      = load_data_q;
    assign load_valid     = load_valid_q;
    assign fault          = fault_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu.
module tb_riscv_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        dmem_rd;
    logic        dmem_wr;
    logic [2:0]  ld_st_funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        fault;

    int n_assert = 0;
    int n_fail   = 0;

    riscv_lsu_if #(.NB_WORD(32), .NB_ADDR(7), .NB_BE(4)) bus ();

    riscv_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .dmem_rd      (dmem_rd),
        .dmem_wr      (dmem_wr),
        .ld_st_funct3 (ld_st_funct3),
        .addr         (addr),
        .store_data   (store_data),
        .stall        (stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .fault        (fault),
        .dmem         (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
        in_valid     = 1'b1;
        dmem_rd      = rd;
        dmem_wr      = wr;
        ld_st_funct3 = f3;
        addr         = a;
        store_data   = d;
    endtask

    task automatic drop();
        in_valid = 1'b0;
        dmem_rd  = 1'b0;
        dmem_wr  = 1'b0;
    endtask

    task automatic bad_access(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a);
        present(rd, wr, f3, a, 32'h0);
        #1;
        check({tag, " stall c0"}, {31'b0, stall}, 32'd0);
        cyc();
        drop();
        #1;
        check({tag, " fault"}, {31'b0, fault}, 32'd1);
        check({tag, " mem_req"}, {31'b0, bus.mem_req}, 32'd0);
        check({tag, " stall c1"}, {31'b0, stall}, 32'd0);
        cyc();
        check({tag, " fault clear"}, {31'b0, fault}, 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        dmem_rd       = 1'b0;
        dmem_wr       = 1'b0;
        ld_st_funct3  = 3'b000;
        addr          = 32'h0;
        store_data    = 32'h0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        cyc();
        cyc();
        // Reset state, with an access presented to show stall is forced low.
        present(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        #1;
        check("rst stall", {31'b0, stall}, 32'd0);
        check("rst mem_req", {31'b0, bus.mem_req}, 32'd0);
        check("rst mem_we", {31'b0, bus.mem_we}, 32'd0);
        check("rst mem_be", {28'b0, bus.mem_be}, 32'd0);
        check("rst mem_addr", {25'b0, bus.mem_addr}, 32'd0);
        check("rst mem_wdata", bus.mem_wdata, 32'd0);
        check("rst load_data", load_data, 32'd0);
        check("rst load_valid", {31'b0, load_valid}, 32'd0);
        check("rst fault", {31'b0, fault}, 32'd0);
        drop();
        rst = 1'b0;
        cyc();

        // 1: SW 0x08, zero-wait memory
        bus.mem_ready = 1'b1;
        present(1'b0, 1'b1, 3'b010, 32'h08, 32'hDEADBEEF);
        #1;
        check("sw stall c0", {31'b0, stall}, 32'd1);
        check("sw req c0", {31'b0, bus.mem_req}, 32'd0);
        cyc();
        drop();
        #1;
        check("sw req c1", {31'b0, bus.mem_req}, 32'd1);
        check("sw addr", {25'b0, bus.mem_addr}, 32'h08);
        check("sw be", {28'b0, bus.mem_be}, 32'hF);
        check("sw wdata", bus.mem_wdata, 32'hDEADBEEF);
        check("sw we", {31'b0, bus.mem_we}, 32'd1);
        check("sw stall c1", {31'b0, stall}, 32'd1);
        cyc();
        check("sw stall c2", {31'b0, stall}, 32'd0);
        check("sw req c2", {31'b0, bus.mem_req}, 32'd0);
        check("sw load_valid", {31'b0, load_valid}, 32'd0);
        cyc();

        // 2: LB / LBU at 0x0B
        bus.mem_rdata = 32'h80FF0000;
        present(1'b1, 1'b0, 3'b000, 32'h0B, 32'h0);
        cyc();
        drop();
        #1;
        check("lb addr", {25'b0, bus.mem_addr}, 32'h08);
        check("lb we", {31'b0, bus.mem_we}, 32'd0);
        cyc();
        check("lb load_valid", {31'b0, load_valid}, 32'd1);
        check("lb load_data", load_data, 32'hFFFFFF80);
        check("lb stall done", {31'b0, stall}, 32'd0);
        cyc();
        check("lb valid drop", {31'b0, load_valid}, 32'd0);
        present(1'b1, 1'b0, 3'b100, 32'h0B, 32'h0);
        cyc();
        drop();
        cyc();
        check("lbu load_valid", {31'b0, load_valid}, 32'd1);
        check("lbu load_data", load_data, 32'h00000080);
        cyc();

        // 3: SH at 0x06
        present(1'b0, 1'b1, 3'b001, 32'h06, 32'h00001234);
        cyc();
        drop();
        #1;
        check("sh addr", {25'b0, bus.mem_addr}, 32'h04);
        check("sh be", {28'b0, bus.mem_be}, 32'hC);
        check("sh wdata", bus.mem_wdata, 32'h12341234);
        cyc();
        cyc();

        // 4: illegal accesses
        bad_access("lw mis", 1'b1, 1'b0, 3'b010, 32'h06);
        bad_access("sh mis", 1'b0, 1'b1, 3'b001, 32'h03);
        bad_access("ld f3=111", 1'b1, 1'b0, 3'b111, 32'h00);
        bad_access("rd+wr", 1'b1, 1'b1, 3'b000, 32'h00);

        // 5: LW at 0x10 with wait states; ready low in cycles 0..2, high in cycle 3
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h11223344;
        present(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        #1;
        check("lw wait stall c0", {31'b0, stall}, 32'd1);
        for (int c = 1; c <= 3; c++) begin
            cyc();
            present(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
            if (c == 3) bus.mem_ready = 1'b1;
            #1;
            check("lw wait req", {31'b0, bus.mem_req}, 32'd1);
            check("lw wait addr", {25'b0, bus.mem_addr}, 32'h10);
            check("lw wait be", {28'b0, bus.mem_be}, 32'hF);
            check("lw wait stall", {31'b0, stall}, 32'd1);
        end
        cyc();
        drop();
        bus.mem_ready = 1'b0;
        #1;
        check("lw wait done stall", {31'b0, stall}, 32'd0);
        check("lw wait load_valid", {31'b0, load_valid}, 32'd1);
        check("lw wait load_data", load_data, 32'h11223344);
        cyc();

        // 6: reset while BUSY, then a late ready
        present(1'b1, 1'b0, 3'b001, 32'h02, 32'h0);
        cyc();
        drop();
        #1;
        check("rstb req busy", {31'b0, bus.mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstb stall forced", {31'b0, stall}, 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        check("rstb req", {31'b0, bus.mem_req}, 32'd0);
        check("rstb stall", {31'b0, stall}, 32'd0);
        bus.mem_ready = 1'b1;
        cyc();
        bus.mem_ready = 1'b0;
        check("rstb late ready", {31'b0, load_valid}, 32'd0);
        check("rstb req after", {31'b0, bus.mem_req}, 32'd0);
        cyc();
        check("rstb late ready 2", {31'b0, load_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
